// File: rtl/oai211_arc_sweep_pkg.sv
// Shared types and the arc table for the OAI211 arc-sweep controller.
// Drive vectors are packed as {A, B, C1, C2}.
package oai211_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_REPORT
  } state_t;

  typedef enum logic [1:0] {
    SW_A,
    SW_B,
    SW_C1,
    SW_C2
  } sw_sel_t;

  // sides holds the fixed inputs; the switching input's bit is don't-care (0)
  typedef struct packed {
    sw_sel_t    sel;
    logic [3:0] sides;
  } arc_entry_t;

  localparam int unsigned NUM_ARCS  = 8;
  localparam int unsigned NUM_MEAS  = 2 * NUM_ARCS;
  localparam int unsigned RES_CNT_W = 8;

  localparam arc_entry_t ARC_TABLE [NUM_ARCS] = '{
    '{sel: SW_A,  sides: 4'b0101},
    '{sel: SW_A,  sides: 4'b0110},
    '{sel: SW_A,  sides: 4'b0111},
    '{sel: SW_B,  sides: 4'b1001},
    '{sel: SW_B,  sides: 4'b1010},
    '{sel: SW_B,  sides: 4'b1011},
    '{sel: SW_C1, sides: 4'b1100},
    '{sel: SW_C2, sides: 4'b1100}
  };

  // 'edge' is reserved, so the edge direction field is named rising
  typedef struct packed {
    logic [2:0]           arc;
    logic                 rising;
    logic [RES_CNT_W-1:0] cnt;
    logic                 to;
    logic                 bad;
  } result_t;

  function automatic logic [1:0] sw_pos(input sw_sel_t sel);
    logic [1:0] pos;
    case (sel)
      SW_A:    pos = 2'd3;
      SW_B:    pos = 2'd2;
      SW_C1:   pos = 2'd1;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  // Pre-launch vector: switching input low before a rise, high before a fall
  function automatic logic [3:0] pre_vector(input logic [2:0] arc, input logic rise);
    logic [3:0] v;
    v = ARC_TABLE[arc].sides;
    v[sw_pos(ARC_TABLE[arc].sel)] = ~rise;
    return v;
  endfunction

endpackage

// File: rtl/oai211_arc_sweep_zn_sync.sv
// Two-flop synchronizer for the asynchronous CUT output, with a
// configurable reset value so the idle level is seen from the first cycle.
module zn_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/oai211_arc_sweep.sv
// Arc-sweep controller: walks the OAI211 CUT through 8 arcs x 2 edges,
// measuring ZN response delay in CK cycles and reporting over valid/ready.
module oai211_arc_sweep
  import oai211_sweep_pkg::*;
#(
  parameter int unsigned CNT_W   = RES_CNT_W,  // keep equal to RES_CNT_W
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN_IN,
  output logic             A,
  output logic             B,
  output logic             C1,
  output logic             C2,
  output logic             BUSY,
  output logic             DONE,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [2:0]       RES_ARC,
  output logic             RES_EDGE,
  output logic [CNT_W-1:0] RES_CNT,
  output logic             RES_TO,
  output logic             RES_BAD
);

  localparam int unsigned SET_W = $clog2(SETTLE) + 1;

  state_t           state;
  logic [3:0]       drv;
  logic [3:0]       meas;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] wcnt;
  result_t          res;
  logic             res_valid;
  logic             busy;
  logic             done;
  logic             zn_s;

  logic [3:0] meas_nxt;
  logic [2:0] arc_cur;
  logic       rise_cur;
  logic [1:0] sw_cur;

  zn_sync #(.RST_VAL(1'b1)) u_zn_sync (
    .clk (CK),
    .rst (RST),
    .d   (ZN_IN),
    .q   (zn_s)
  );

  // Even measurement index = rising edge, odd = falling edge of the same arc
  assign meas_nxt = meas + 4'd1;
  assign arc_cur  = meas[3:1];
  assign rise_cur = ~meas[0];
  assign sw_cur   = sw_pos(ARC_TABLE[arc_cur].sel);

  always_ff @(posedge CK) begin
    if (RST) begin
      state      <= ST_IDLE;
      drv        <= '0;
      meas       <= '0;
      settle_cnt <= '0;
      wcnt       <= '0;
      res        <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          drv <= '0;
          if (START) begin
            state      <= ST_SETTLE;
            busy       <= 1'b1;
            meas       <= '0;
            settle_cnt <= '0;
            drv        <= pre_vector(3'd0, 1'b1);
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            // ZN must already sit at 1 before a rise and at 0 before a fall
            if (zn_s != rise_cur) begin
              res.arc    <= arc_cur;
              res.rising <= rise_cur;
              res.cnt    <= '0;
              res.to     <= 1'b0;
              res.bad    <= 1'b1;
              res_valid  <= 1'b1;
              state      <= ST_REPORT;
            end else begin
              state <= ST_LAUNCH;
            end
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        ST_LAUNCH: begin
          drv[sw_cur] <= ~drv[sw_cur];
          wcnt        <= '0;
          state       <= ST_WAIT;
        end

        ST_WAIT: begin
          if (zn_s == ~rise_cur) begin
            res.arc    <= arc_cur;
            res.rising <= rise_cur;
            res.cnt    <= RES_CNT_W'(wcnt);
            res.to     <= 1'b0;
            res.bad    <= 1'b0;
            res_valid  <= 1'b1;
            state      <= ST_REPORT;
          end else if (wcnt == CNT_W'(TIMEOUT)) begin
            res.arc    <= arc_cur;
            res.rising <= rise_cur;
            res.cnt    <= RES_CNT_W'(TIMEOUT);
            res.to     <= 1'b1;
            res.bad    <= 1'b0;
            res_valid  <= 1'b1;
            state      <= ST_REPORT;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end

        ST_REPORT: begin
          if (res_valid && RES_READY) begin
            res_valid <= 1'b0;
            if (meas == 4'(NUM_MEAS - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              drv   <= '0;
            end else begin
              meas       <= meas_nxt;
              settle_cnt <= '0;
              drv        <= pre_vector(meas_nxt[3:1], ~meas_nxt[0]);
              state      <= ST_SETTLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign A         = drv[3];
  assign B         = drv[2];
  assign C1        = drv[1];
  assign C2        = drv[0];
  assign BUSY      = busy;
  assign DONE      = done;
  assign RES_VALID = res_valid;
  assign RES_ARC   = res.arc;
  assign RES_EDGE  = res.rising;
  assign RES_CNT   = CNT_W'(res.cnt);
  assign RES_TO    = res.to;
  assign RES_BAD   = res.bad;

endmodule

// File: tb/tb_oai211_arc_sweep.sv
// Scoreboard bench for oai211_arc_sweep with a behavioural OAI211 CUT
// (zero delay, 5-cycle delay, or ZN stuck at 1).
module tb_oai211_arc_sweep;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ZN_IN;
  logic       RES_READY = 1'b1;
  logic       A, B, C1, C2;
  logic       BUSY, DONE, RES_VALID;
  logic [2:0] RES_ARC;
  logic       RES_EDGE;
  logic [7:0] RES_CNT;
  logic       RES_TO, RES_BAD;

  int checks   = 0;
  int errors   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int mode     = 0;  // 0 zero-delay, 1 five-cycle delay, 2 stuck at 1

  typedef struct packed {
    logic [2:0] arc;
    logic       rising;
    logic [7:0] cnt;
    logic       to;
    logic       bad;
  } exp_t;

  exp_t exp_q[$];

  logic       zn_ideal;
  logic [4:0] pipe = '1;

  oai211_arc_sweep #(.CNT_W(8), .SETTLE(4), .TIMEOUT(200)) dut (
    .CK        (CK),
    .RST       (RST),
    .START     (START),
    .ZN_IN     (ZN_IN),
    .A         (A),
    .B         (B),
    .C1        (C1),
    .C2        (C2),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_ARC   (RES_ARC),
    .RES_EDGE  (RES_EDGE),
    .RES_CNT   (RES_CNT),
    .RES_TO    (RES_TO),
    .RES_BAD   (RES_BAD)
  );

  always #5 CK = ~CK;

  assign zn_ideal = ~((C1 | C2) & A & B);
  always @(posedge CK) pipe <= {pipe[3:0], zn_ideal};
  assign ZN_IN = (mode == 2) ? 1'b1 : (mode == 1) ? pipe[4] : zn_ideal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // kind 0: cnt 2; kind 1: cnt 7; kind 2: rise timeout 200, fall bad
  task automatic push_sweep(input int unsigned first, input int unsigned n, input int kind);
    exp_t e;
    for (int unsigned m = first; m < first + n; m++) begin
      e.arc    = 3'(m / 2);
      e.rising = (m % 2 == 0);
      e.to     = 1'b0;
      e.bad    = 1'b0;
      if (kind == 0)      e.cnt = 8'd2;
      else if (kind == 1) e.cnt = 8'd7;
      else if (e.rising) begin
        e.cnt = 8'd200;
        e.to  = 1'b1;
      end else begin
        e.cnt = 8'd0;
        e.bad = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned limit);
    int unsigned n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      step();
      n++;
      seen = DONE;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CK);
      if (RES_VALID && RES_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got arc %0d edge %0d with no result required",
                   RES_ARC, RES_EDGE);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("res%0d", acc_cnt), 32'({RES_ARC, RES_EDGE, RES_CNT, RES_TO, RES_BAD}),
              32'(e));
        end
        acc_cnt++;
      end
      if (DONE) begin
        done_cnt++;
        chk("done_busy", 32'(BUSY), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n;
    int base;
    int dc;

    // reset state
    repeat (3) step();
    @(negedge CK);
    chk("rst_drive", 32'({A, B, C1, C2}), 32'd0);
    chk("rst_flags", 32'({BUSY, DONE, RES_VALID}), 32'd0);
    chk("rst_res", 32'({RES_ARC, RES_EDGE, RES_CNT, RES_TO, RES_BAD}), 32'd0);
    step();
    RST = 1'b0;
    step();

    // zero-delay sweep with a 10-cycle ready stall on result 3
    mode = 0;
    push_sweep(0, 16, 0);
    pulse_start();
    chk("busy_on1", 32'(BUSY), 32'd1);
    n = 0;
    while (n < 200 && acc_cnt < 3) begin
      step();
      n++;
    end
    chk("reach_res3", 32'(acc_cnt >= 3), 32'd1);
    RES_READY = 1'b0;
    n = 0;
    while (n < 50 && !RES_VALID) begin
      step();
      n++;
    end
    chk("res3_valid", 32'(RES_VALID), 32'd1);
    repeat (10) begin
      @(negedge CK);
      chk("hold_res3", 32'({RES_VALID, RES_ARC, RES_EDGE, RES_CNT, A, B, C1, C2}),
          32'({1'b1, 3'd1, 1'b0, 8'd2, 4'b0110}));
    end
    step();
    RES_READY = 1'b1;
    wait_done("done1", 400);
    chk("q_empty1", 32'(exp_q.size()), 32'd0);
    chk("idle_drive", 32'({A, B, C1, C2}), 32'd0);

    // START on the DONE cycle; 5-cycle CUT; stray START mid-sweep
    mode = 1;
    push_sweep(0, 16, 1);
    pulse_start();
    chk("busy_on2", 32'(BUSY), 32'd1);
    repeat (30) step();
    pulse_start();
    wait_done("done2", 600);
    chk("q_empty2", 32'(exp_q.size()), 32'd0);

    // reset during WAIT of arc 4 rise
    step();
    push_sweep(0, 8, 1);
    base = acc_cnt;
    pulse_start();
    n = 0;
    while (n < 300 && acc_cnt < base + 8) begin
      step();
      n++;
    end
    chk("reach_arc4", 32'(acc_cnt - base), 32'd8);
    n = 0;
    while (n < 20 && !B) begin
      step();
      n++;
    end
    chk("arc4_launch", 32'(B), 32'd1);
    RST = 1'b1;
    step();
    chk("rstmid_drive", 32'({A, B, C1, C2}), 32'd0);
    chk("rstmid_flags", 32'({BUSY, DONE, RES_VALID}), 32'd0);
    RST = 1'b0;
    dc = done_cnt;
    repeat (20) step();
    chk("rstmid_no_done", 32'(done_cnt), 32'(dc));
    chk("q_empty3", 32'(exp_q.size()), 32'd0);

    mode = 0;
    push_sweep(0, 16, 0);
    pulse_start();
    wait_done("done4", 400);
    chk("q_empty4", 32'(exp_q.size()), 32'd0);

    // ZN stuck at 1
    step();
    mode = 2;
    push_sweep(0, 16, 2);
    pulse_start();
    wait_done("done5", 5000);
    chk("q_empty5", 32'(exp_q.size()), 32'd0);

    step();
    chk("done_total", 32'(done_cnt), 32'd4);
    chk("acc_total", 32'(acc_cnt), 32'd72);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
